// File: rtl/add_sub_pipe.sv
// Pipelined adder/subtractor. The WIDTH-bit carry chain is cut into STAGES
// equal slices, and each pipeline stage adds one slice. The carry, the
// operands and the valid bit travel with the data. One global advance
// signal gives full backpressure.

// One slice of the carry chain: an S-bit add with carry in and carry out.
module add_sub_slice #(
    parameter int S = 8
) (
    input  logic [S-1:0] a,
    input  logic [S-1:0] b,
    input  logic         ci,
    output logic [S-1:0] s,
    output logic         co
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {{S{1'b0}}, ci};
endmodule

module add_sub_pipe #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int S = WIDTH / STAGES;

    // a and b_eff ride along for the slices still to be added.
    // s holds the low slices that are already finished.
    // c is the carry into the next slice.
    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] s;
        logic             c;
    } stage_t;

    logic [STAGES:0] vld_pipe;
    logic            adv;
    stage_t          entry;
    stage_t          st_d [STAGES];
    stage_t          st_q [STAGES];
    logic            ovf_d, zero_d, ovf_q, zero_q;

    // All stages move together. If the output is occupied and not taken,
    // every stage holds. Bubbles are not squeezed out.
    assign adv         = !vld_pipe[STAGES] | out_ready;
    assign in_ready    = adv & !rst;
    assign vld_pipe[0] = in_valid;

    // Subtraction is a + ~b + 1. The +1 enters as the carry into slice 0.
    always_comb begin
        entry.a = a;
        entry.b = sub ? ~b : b;
        entry.s = '0;
        entry.c = sub;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_t           src;
        logic [S-1:0]     slice_s;
        logic             slice_c;
        logic [WIDTH-1:0] merged;

        if (k == 0) begin : g_first
            assign src = entry;
        end else begin : g_rest
            assign src = st_q[k-1];
        end

        add_sub_slice #(.S(S)) u_slice (
            .a  (src.a[k*S +: S]),
            .b  (src.b[k*S +: S]),
            .ci (src.c),
            .s  (slice_s),
            .co (slice_c)
        );

        // Insert this stage's slice. The lower slices pass through unchanged.
        always_comb begin
            merged            = src.s;
            merged[k*S +: S]  = slice_s;
        end

        assign st_d[k] = '{a: src.a, b: src.b, s: merged, c: slice_c};

        // Stage register. It loads only on a global advance.
        always_ff @(posedge clk) begin
            if (rst)      st_q[k] <= '0;
            else if (adv) st_q[k] <= st_d[k];
        end
    end

    // Valid shift register. Its bits move in lock-step with the stage data.
    always_ff @(posedge clk) begin
        if (rst)      vld_pipe[STAGES:1] <= '0;
        else if (adv) vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
    end

    // Flags come from the completed sum and are registered together with it.
    assign ovf_d  = (st_d[STAGES-1].a[WIDTH-1] == st_d[STAGES-1].b[WIDTH-1]) &
                    (st_d[STAGES-1].s[WIDTH-1] != st_d[STAGES-1].a[WIDTH-1]);
    assign zero_d = (st_d[STAGES-1].s == '0);

    // Flag registers. They sit next to the final stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else if (adv) begin
            ovf_q  <= ovf_d;
            zero_q <= zero_d;
        end
    end

    assign out_valid = vld_pipe[STAGES];
    assign sum       = st_q[STAGES-1].s;
    assign cout      = st_q[STAGES-1].c;
    assign ovf       = ovf_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_add_sub_pipe.sv
// Bench for add_sub_pipe. Four configurations run side by side:
// (32,4), (8,1), (16,2) and (64,8). Each one has a scoreboard fed by an
// arithmetic reference model.
module tb_add_sub_pipe;
    localparam int NC = 4;
    localparam int CW [NC] = '{32, 8, 16, 64};
    localparam int CS [NC] = '{4, 1, 2, 8};

    typedef struct packed {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
    } res_t;

    typedef struct packed {
        res_t r;
        int   acc;
    } ent_t;

    logic          clk, rst;
    logic [NC-1:0] iv, sb_d, ordy, in_rdy, out_v;
    logic [63:0]   a_d [NC];
    logic [63:0]   b_d [NC];
    logic [63:0]   sum_o [NC];
    logic [2:0]    flg_o [NC];
    int            nout [NC];
    int            qlen [NC];
    int            nchk, npass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    endtask

    // Reference model. It works on plain unsigned and signed integers of width w.
    function automatic res_t model(input int w, input logic [63:0] a, input logic [63:0] b,
                                   input logic sub);
        res_t              r;
        logic [63:0]       m, au, bu;
        logic [64:0]       t;
        logic signed [65:0] sa, sbv, sr, lim;
        m  = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
        au = a & m;
        bu = b & m;
        if (sub) begin
            t      = {1'b0, au} - {1'b0, bu};
            r.cout = (au >= bu);
        end else begin
            t      = {1'b0, au} + {1'b0, bu};
            r.cout = t[w];
        end
        r.sum = t[63:0] & m;
        sa  = $signed({2'b00, au});
        sbv = $signed({2'b00, bu});
        if (au[w-1]) sa  = sa  - (66'sd1 <<< w);
        if (bu[w-1]) sbv = sbv - (66'sd1 <<< w);
        sr    = sub ? sa - sbv : sa + sbv;
        lim   = 66'sd1 <<< (w - 1);
        r.ovf  = (sr >= lim) || (sr < -lim);
        r.zero = (r.sum == 64'd0);
        return r;
    endfunction

    for (genvar g = 0; g < NC; g++) begin : cfg
        localparam int W  = CW[g];
        localparam int ST = CS[g];
        logic         ir, ov, co, of, zr;
        logic [W-1:0] sm;

        add_sub_pipe #(.WIDTH(W), .STAGES(ST)) dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (iv[g]),
            .in_ready  (ir),
            .a         (a_d[g][W-1:0]),
            .b         (b_d[g][W-1:0]),
            .sub       (sb_d[g]),
            .out_valid (ov),
            .out_ready (ordy[g]),
            .sum       (sm),
            .cout      (co),
            .ovf       (of),
            .zero      (zr)
        );

        assign in_rdy[g] = ir;
        assign out_v[g]  = ov;
        assign sum_o[g]  = 64'(sm);
        assign flg_o[g]  = {co, of, zr};

        // Scoreboard. The inputs change just after each posedge, so the
        // handshakes seen here are exactly the ones the next posedge performs.
        initial begin
            ent_t         q[$];
            int           cyc = 0, last_stall = -1;
            bit           seen = 0, prev_stall = 0, prev_rst = 0;
            logic [W-1:0] p_sum = '0;
            logic [2:0]   p_flg = '0;
            string        tag;
            tag = $sformatf("cfg%0d", g);
            forever begin
                @(negedge clk);
                cyc++;
                chk({tag, " in_ready"}, 64'(ir), 64'((!ov | ordy[g]) & !rst));
                if (rst && prev_rst) begin
                    chk({tag, " reset out_valid"}, 64'(ov), 64'd0);
                    chk({tag, " reset sum"}, 64'(sm), 64'd0);
                    chk({tag, " reset flags"}, 64'({co, of, zr}), 64'd0);
                end else if (ov) begin
                    if (q.size() == 0) begin
                        chk({tag, " spurious out_valid"}, 64'(ov), 64'd0);
                    end else begin
                        chk({tag, " sum"}, 64'(sm), q[0].r.sum);
                        chk({tag, " cout/ovf/zero"}, 64'({co, of, zr}),
                            64'({q[0].r.cout, q[0].r.ovf, q[0].r.zero}));
                        if (!seen) begin
                            seen = 1;
                            if (last_stall < q[0].acc)
                                chk({tag, " latency"}, 64'(cyc - q[0].acc), 64'(ST));
                            else
                                chk({tag, " stalled latency"}, 64'(cyc - q[0].acc > ST), 64'd1);
                        end
                    end
                end
                if (prev_stall && !prev_rst) begin
                    chk({tag, " stall hold valid"}, 64'(ov), 64'd1);
                    chk({tag, " stall hold sum"}, 64'(sm), 64'(p_sum));
                    chk({tag, " stall hold flags"}, 64'({co, of, zr}), 64'(p_flg));
                end
                prev_stall = ov & !ordy[g] & !rst;
                if (prev_stall) last_stall = cyc;
                p_sum = sm;
                p_flg = {co, of, zr};
                if (rst) begin
                    q.delete();
                    seen = 0;
                end else begin
                    if (ov && ordy[g]) begin
                        if (q.size() > 0) void'(q.pop_front());
                        seen = 0;
                        nout[g]++;
                    end
                    if (iv[g] && ir)
                        q.push_back('{r: model(W, a_d[g], b_d[g], sb_d[g]), acc: cyc});
                end
                prev_rst = rst;
                qlen[g]  = q.size();
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [63:0] rv();
        logic [63:0] v;
        case ($urandom_range(0, 5))
            0:       v = 64'd0;
            1:       v = '1;
            2:       v = 64'd1 << $urandom_range(0, 63);
            3:       v = ~(64'd1 << $urandom_range(0, 63));
            default: v = {$urandom, $urandom};
        endcase
        return v;
    endfunction

    task automatic drive_rand(input int pv, input int pr);
        for (int g = 0; g < NC; g++) begin
            iv[g]   = ($urandom_range(0, 99) < pv);
            a_d[g]  = rv();
            b_d[g]  = rv();
            sb_d[g] = 1'($urandom_range(0, 1));
            ordy[g] = ($urandom_range(0, 99) < pr);
        end
    endtask

    task automatic pin(input string nm, input logic [63:0] av, input logic [63:0] bv,
                       input logic s, input logic [63:0] es, input logic [2:0] ef);
        res_t r;
        r = model(32, av, bv, s);
        chk({"model ", nm, " sum"}, r.sum, es);
        chk({"model ", nm, " flags"}, 64'({r.cout, r.ovf, r.zero}), 64'(ef));
    endtask

    // Single operation on cfg0 (32,4). The result is checked against
    // hand-computed values.
    task automatic directed(input string nm, input logic [31:0] av, input logic [31:0] bv,
                            input logic s, input logic [31:0] es, input logic [2:0] ef);
        int n;
        iv[0] = 1'b1; a_d[0] = 64'(av); b_d[0] = 64'(bv); sb_d[0] = s; ordy[0] = 1'b1;
        step();
        iv[0] = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_v[0] && n < 20);
        chk({nm, " latency"}, 64'(n), 64'd4);
        chk({nm, " sum"}, sum_o[0], 64'(es));
        chk({nm, " cout/ovf/zero"}, 64'(flg_o[0]), 64'(ef));
        step();
    endtask

    initial begin
        int n0, cnt;
        nchk = 0; npass = 0;
        rst = 1'b1; iv = '0; sb_d = '0; ordy = '1;
        for (int g = 0; g < NC; g++) begin
            a_d[g] = '0; b_d[g] = '0; nout[g] = 0; qlen[g] = 0;
        end

        pin("carry", 64'h0000_FFFF, 64'd1, 1'b0, 64'h0001_0000, 3'b000);
        pin("ovf",   64'h7FFF_FFFF, 64'd1, 1'b0, 64'h8000_0000, 3'b010);
        pin("wrap",  64'hFFFF_FFFF, 64'd1, 1'b0, 64'd0,         3'b101);
        pin("sub",   64'd5,         64'd7, 1'b1, 64'hFFFF_FFFE, 3'b000);

        // Reset held with in_valid high.
        step();
        iv = '1;
        step();
        step();
        @(negedge clk);
        chk("reset in_ready", 64'(in_rdy[0]), 64'd0);
        chk("reset out_valid", 64'(out_v[0]), 64'd0);
        chk("reset sum", sum_o[0], 64'd0);
        step();
        rst = 1'b0; iv = '0;
        step();

        directed("carry-cross", 32'h0000_FFFF, 32'd1, 1'b0, 32'h0001_0000, 3'b000);
        directed("signed-ovf",  32'h7FFF_FFFF, 32'd1, 1'b0, 32'h8000_0000, 3'b010);
        directed("wrap-zero",   32'hFFFF_FFFF, 32'd1, 1'b0, 32'd0,         3'b101);
        directed("sub-borrow",  32'd5,         32'd7, 1'b1, 32'hFFFF_FFFE, 3'b000);

        // Three operations in flight, then a reset pulse that must discard them.
        drive_rand(100, 100);
        step();
        drive_rand(100, 100);
        step();
        drive_rand(100, 100);
        step();
        rst = 1'b1; iv = '0;
        step();
        rst = 1'b0;
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_v[0]) cnt++;
        end
        chk("reset flush out_valid count", 64'(cnt), 64'd0);
        step();

        // Streaming: 100 back-to-back operations with the consumer always ready.
        n0 = nout[0];
        for (int i = 0; i < 100; i++) begin
            drive_rand(100, 100);
            step();
        end
        iv = '0;
        for (int i = 0; i < 12; i++) step();
        chk("stream result count", 64'(nout[0] - n0), 64'd100);

        // Backpressure: random in_valid and random out_ready.
        for (int i = 0; i < 400; i++) begin
            drive_rand(75, 50);
            step();
        end

        // Drain.
        iv = '0; ordy = '1;
        for (int i = 0; i < 20; i++) step();
        for (int g = 0; g < NC; g++)
            chk($sformatf("cfg%0d drained", g), 64'(qlen[g]), 64'd0);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end
endmodule
